// File: rtl/dmx2_8bit_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input stream steered by s into
// two independent first-word fall-through FIFOs, one per output channel.
module dmx2_8bit_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             s,
  output logic [WIDTH-1:0] y0,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [CW-1:0]    y0_count,
  output logic [WIDTH-1:0] y1,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [CW-1:0]    y1_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]            sel_s;
  logic [1:0]            ready_s;
  logic [1:0]            full_s;
  logic [1:0]            push_s;
  logic [1:0]            pop_s;
  logic [1:0][WIDTH-1:0] head_s;
  logic [1:0][CW-1:0]    cnt_s;

  assign sel_s   = {s, ~s};
  assign ready_s = {y1_ready, y0_ready};
  // Fullness alone gates the push; a pop in the same cycle does not free a slot.
  assign d_ready = ~full_s[s];

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;

    assign full_s[k] = (count_r == CW'(DEPTH));
    assign push_s[k] = d_valid & ~full_s[k] & sel_s[k];
    assign pop_s[k]  = (count_r != {CW{1'b0}}) & ready_s[k];

    // Occupancy update from this cycle's push/pop pair.
    always_comb begin
      count_nxt_s = count_r;
      case ({push_s[k], pop_s[k]})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end

    // Storage, pointers and count; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        count_r  <= {CW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
          mem_r[i] <= {WIDTH{1'b0}};
        end
      end else begin
        if (push_s[k]) begin
          mem_r[wr_ptr_r] <= d;
          wr_ptr_r        <= wr_ptr_r + AW'(1);
        end
        if (pop_s[k]) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        count_r <= count_nxt_s;
      end
    end

    assign head_s[k] = (count_r != {CW{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
    assign cnt_s[k]  = count_r;
  end

  assign y0       = head_s[0];
  assign y0_valid = (cnt_s[0] != {CW{1'b0}});
  assign y0_count = cnt_s[0];
  assign y1       = head_s[1];
  assign y1_valid = (cnt_s[1] != {CW{1'b0}});
  assign y1_count = cnt_s[1];

endmodule

// File: tb/tb_dmx2_8bit_buf.sv
// Scoreboard bench for dmx2_8bit_buf: directed pushes queue expected words per
// channel, an independent monitor pops and compares on every output handshake.
module tb_dmx2_8bit_buf;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] d = 8'h00;
  logic       d_valid = 1'b0;
  logic       d_ready;
  logic       s = 1'b0;
  logic [7:0] y0, y1;
  logic       y0_valid, y1_valid;
  logic       y0_ready = 1'b0;
  logic       y1_ready = 1'b0;
  logic [1:0] y0_count, y1_count;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         n_pop1 = 0;
  logic       tog_en = 1'b0;

  dmx2_8bit_buf #(.WIDTH(8), .DEPTH(2), .CW(2)) dut (
    .clk(clk), .reset_n(reset_n), .d(d), .d_valid(d_valid), .d_ready(d_ready), .s(s),
    .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready), .y0_count(y0_count),
    .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready), .y1_count(y1_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word to channel ch; expected value is queued once the bench sees it accepted.
  task automatic push_word(input logic ch, input logic [7:0] val);
    logic got;
    got = 1'b0;
    s = ch;
    d = val;
    d_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (d_ready) got = 1'b1;
      else step();
    end
    check("push_accept", {31'd0, got}, 32'd1);
    if (got) begin
      if (ch) q1.push_back(val);
      else    q0.push_back(val);
      step();
    end
    d_valid = 1'b0;
  endtask

  // Monitor: every output handshake must match the oldest word queued for that channel.
  always @(negedge clk) begin
    if (reset_n) begin
      if (y0_valid && y0_ready) begin
        if (q0.size() == 0) check("y0_unexpected", {24'd0, y0}, 32'hFFFF_FFFF);
        else check("y0_order", {24'd0, y0}, {24'd0, q0.pop_front()});
      end
      if (y1_valid && y1_ready) begin
        n_pop1++;
        if (q1.size() == 0) check("y1_unexpected", {24'd0, y1}, 32'hFFFF_FFFF);
        else check("y1_order", {24'd0, y1}, {24'd0, q1.pop_front()});
      end
    end
  end

  initial begin
    // T1 reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
    check("rst_y1_valid", {31'd0, y1_valid}, 32'd0);
    check("rst_y0", {24'd0, y0}, 32'd0);
    check("rst_y1", {24'd0, y1}, 32'd0);
    check("rst_y0_count", {30'd0, y0_count}, 32'd0);
    check("rst_y1_count", {30'd0, y1_count}, 32'd0);
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("rel_d_ready", {31'd0, d_ready}, 32'd1);

    // T2 fill channel 0, then route to channel 1
    step();
    push_word(1'b0, 8'h11);
    push_word(1'b0, 8'h22);
    s = 1'b0;
    @(negedge clk);
    check("fill_y0_count", {30'd0, y0_count}, 32'd2);
    check("full_d_ready", {31'd0, d_ready}, 32'd0);
    s = 1'b1;
    #1;
    check("sel1_d_ready", {31'd0, d_ready}, 32'd1);
    step();
    push_word(1'b1, 8'h33);
    @(negedge clk);
    check("t2_y1", {24'd0, y1}, 32'h33);
    check("t2_y1_valid", {31'd0, y1_valid}, 32'd1);
    check("t2_y0_head", {24'd0, y0}, 32'h11);

    // T3 drain channel 0
    step();
    y0_ready = 1'b1;
    @(negedge clk);
    check("drain_first", {24'd0, y0}, 32'h11);
    step();
    @(negedge clk);
    check("drain_second", {24'd0, y0}, 32'h22);
    step();
    y0_ready = 1'b0;
    @(negedge clk);
    check("empty_y0_valid", {31'd0, y0_valid}, 32'd0);
    check("empty_y0", {24'd0, y0}, 32'd0);
    check("empty_y0_count", {30'd0, y0_count}, 32'd0);
    step();
    y1_ready = 1'b1;
    step();
    y1_ready = 1'b0;
    @(negedge clk);
    check("empty_y1_count", {30'd0, y1_count}, 32'd0);

    // T4 simultaneous push and pop at count 1
    step();
    push_word(1'b0, 8'h44);
    s = 1'b0;
    d = 8'h55;
    d_valid = 1'b1;
    y0_ready = 1'b1;
    @(negedge clk);
    check("t4_d_ready", {31'd0, d_ready}, 32'd1);
    check("t4_count_before", {30'd0, y0_count}, 32'd1);
    q0.push_back(8'h55);
    step();
    d_valid = 1'b0;
    y0_ready = 1'b0;
    @(negedge clk);
    check("t4_count_after", {30'd0, y0_count}, 32'd1);
    check("t4_y0", {24'd0, y0}, 32'h55);
    step();
    y0_ready = 1'b1;
    step();
    y0_ready = 1'b0;

    // T5 stream through channel 1 across pointer wrap with a toggling consumer
    n_pop1 = 0;
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk);
          #2;
          if (tog_en) y1_ready = ~y1_ready;
        end
      end
    join_none
    for (int i = 0; i < 5; i++) push_word(1'b1, 8'hA0 + 8'(i));
    for (int i = 0; i < 40 && (q1.size() != 0 || y1_count != 2'd0); i++) step();
    tog_en = 1'b0;
    @(posedge clk);
    #3;
    y1_ready = 1'b0;
    check("t5_pop_count", n_pop1, 32'd5);
    check("t5_left", q1.size(), 32'd0);

    // T6 asynchronous reset with both channels occupied
    push_word(1'b0, 8'h66);
    push_word(1'b1, 8'h77);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_y0_valid", {31'd0, y0_valid}, 32'd0);
    check("arst_y1_valid", {31'd0, y1_valid}, 32'd0);
    check("arst_y0", {24'd0, y0}, 32'd0);
    check("arst_y1", {24'd0, y1}, 32'd0);
    check("arst_counts", {28'd0, y0_count, y1_count}, 32'd0);
    q0.delete();
    q1.delete();
    #1;
    reset_n = 1'b1;
    step();
    push_word(1'b0, 8'h88);
    @(negedge clk);
    check("resume_y0", {24'd0, y0}, 32'h88);
    check("resume_count", {30'd0, y0_count}, 32'd1);
    step();
    y0_ready = 1'b1;
    step();
    y0_ready = 1'b0;
    repeat (2) step();
    check("final_q0_empty", q0.size(), 32'd0);
    check("final_q1_empty", q1.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
